// File: rtl/scan_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : scan_config_loader
//  Description : Streams configuration words LSB-first into the tile
//                connection scan chain. The bits leaving the chain tail
//                (the previous configuration) are packed back into readback
//                words.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_config_loader #(
   parameter int CHAIN_LEN  = 64,
   parameter int WORD_WIDTH = 8
) (
   input  logic                  scan_clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] cfg_data,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic                  conn_scan_en,
   output logic                  conn_scan_in,
   input  logic                  conn_scan_out,
   output logic [WORD_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  done
);

   localparam int NWORDS    = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_WIDTH;
   localparam int BW        = $clog2(WORD_WIDTH + 1);
   localparam int NWW       = $clog2(NWORDS + 1);
   localparam int CW        = $clog2(WORD_WIDTH);

   localparam logic [BW-1:0]  BITS_ZERO = '0;
   localparam logic [BW-1:0]  BITS_ONE  = BW'(1);
   localparam logic [BW-1:0]  BITS_FULL = BW'(WORD_WIDTH);
   localparam logic [BW-1:0]  BITS_LAST = BW'(LAST_BITS);
   localparam logic [NWW-1:0] WORDS_ALL = NWW'(NWORDS);
   localparam logic [NWW-1:0] WORDS_ONE = NWW'(1);
   localparam logic [CW-1:0]  CAP_TOP   = CW'(WORD_WIDTH - 1);
   localparam logic [CW-1:0]  CAP_ONE   = CW'(1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [WORD_WIDTH-1:0] shreg;
   logic [WORD_WIDTH-1:0] pack;
   logic [WORD_WIDTH-1:0] pack_next;
   logic [BW-1:0]         bits_left;
   logic [NWW-1:0]        words_left;
   logic [CW-1:0]         cap_cnt;
   logic                  accept;
   logic                  last_shift;

   // Serial data always comes straight from the shift register LSB.
   assign conn_scan_in = shreg[0];

   // State register; async reset drops the FSM (and hence the enable) at once.
   always_ff @(posedge scan_clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus the register-derived handshake and shift enable.
   always_comb begin
      state_next   = state;
      conn_scan_en = 1'b0;
      cfg_ready    = 1'b0;
      last_shift   = 1'b0;
      busy         = (state == SHIFT);
      if (state == SHIFT) begin
         conn_scan_en = (bits_left != BITS_ZERO);
         // bits_left==1 in SHIFT always means a shift is happening, so the
         // next word can be taken on the edge that empties the current one.
         cfg_ready    = (words_left != '0) &&
                        ((bits_left == BITS_ZERO) || (bits_left == BITS_ONE));
         last_shift   = (words_left == '0) && (bits_left == BITS_ONE);
      end
      accept = cfg_valid && cfg_ready;
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last_shift) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort) begin
         state_next = IDLE;
      end
   end

   // Readback packer: the incoming tail bit dropped into its slot.
   always_comb begin
      pack_next          = pack;
      pack_next[cap_cnt] = conn_scan_out;
   end

   // Word loading, serial shifting, tail capture and the done/readback pulses.
   always_ff @(posedge scan_clk or posedge reset) begin
      if (reset) begin
         shreg      <= '0;
         pack       <= '0;
         bits_left  <= '0;
         words_left <= '0;
         cap_cnt    <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         done       <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;
         if (abort) begin
            // Partial readback is dropped; the chain keeps whatever shifted.
            shreg      <= '0;
            pack       <= '0;
            bits_left  <= '0;
            words_left <= '0;
            cap_cnt    <= '0;
         end else if (state == IDLE) begin
            if (start) begin
               shreg      <= '0;
               pack       <= '0;
               bits_left  <= '0;
               words_left <= WORDS_ALL;
               cap_cnt    <= '0;
            end
         end else begin
            if (accept) begin
               shreg      <= cfg_data;
               bits_left  <= (words_left == WORDS_ONE) ? BITS_LAST : BITS_FULL;
               words_left <= words_left - WORDS_ONE;
            end else if (conn_scan_en) begin
               shreg     <= shreg >> 1;
               bits_left <= bits_left - BITS_ONE;
            end
            if (conn_scan_en) begin
               if (last_shift || (cap_cnt == CAP_TOP)) begin
                  rd_data  <= pack_next;
                  rd_valid <= 1'b1;
                  pack     <= '0;
                  cap_cnt  <= '0;
               end else begin
                  pack    <= pack_next;
                  cap_cnt <= cap_cnt + CAP_ONE;
               end
            end
            if (last_shift) begin
               // Discarded upper bits of the last word must not linger on scan_in.
               shreg <= '0;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
